// File: rtl/rv32i_types.sv
// Shared fetch-path types: FSM state encoding and the buffered {pc, inst} entry.
package rv32i_types;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  localparam logic [1:0] FIFO_DEPTH = 2'd2;

endpackage

// File: rtl/fetch_ctrl_inst_fifo.sv
// Two-entry in-order instruction buffer with same-cycle flush; head is always exposed.
import rv32i_types::*;

module inst_fifo (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wdata,
  output fetch_entry_t head,
  output logic [1:0]   count
);

  fetch_entry_t mem [2];
  logic         rd_ptr;
  logic         wr_ptr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      // Push and pop together leave the occupancy unchanged.
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: one outstanding imem read, 2-entry buffer, redirect flush.
import rv32i_types::*;

module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h1eceb000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  output logic [3:0]  imem_rmask,
  input  logic [31:0] imem_rdata,
  input  logic        imem_resp,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
);

  fetch_state_t state;
  logic [31:0]  pc;
  logic [31:0]  req_pc;
  logic [1:0]   count;
  fetch_entry_t head;
  fetch_entry_t wdata;
  logic         issue;
  logic         push;
  logic         pop;

  // Issue only from IDLE (nothing outstanding), so pre-pop occupancy alone bounds the FIFO.
  assign issue = rst && (state == IDLE) && !redirect && (count < FIFO_DEPTH);
  assign push  = (state == WAIT) && imem_resp && !redirect;
  assign pop   = inst_valid && !stall && !redirect;

  assign imem_rmask = issue ? 4'hF : 4'h0;
  assign imem_addr  = issue ? pc : 32'h0;

  assign wdata.pc   = req_pc;
  assign wdata.inst = imem_rdata;

  assign inst_valid = (count != 2'd0);
  assign inst       = head.inst;
  assign inst_pc    = head.pc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      pc     <= RESET_PC;
      req_pc <= 32'h0;
    end else begin
      if (redirect) pc <= redirect_pc;
      case (state)
        IDLE: begin
          if (issue) begin
            req_pc <= pc;
            pc     <= pc + 32'd4;
            state  <= WAIT;
          end
        end
        WAIT: begin
          if (imem_resp)     state <= IDLE;
          else if (redirect) state <= DISCARD;
        end
        DISCARD: begin
          if (imem_resp) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  inst_fifo u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .wdata (wdata),
    .head  (head),
    .count (count)
  );

endmodule
